// File: rtl/gpio_in_cond.sv
// Synchronizes and debounces raw GPIO input pins, and captures enabled edges as sticky irq flags.
// Latency: 2 sync edges + DB_TICKS (debounce on, GPIO_IN_DEBOUNCE_EN defined) or a fixed 3 edges (off).
// Backpressure: none; all outputs are free-running registered levels.
module gpio_in_cond #(
    parameter int IN_W     = 8,
    parameter int DB_W     = 16,
    parameter int DB_TICKS = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] pin_in,
    input  logic [IN_W-1:0] rise_en,
    input  logic [IN_W-1:0] fall_en,
    input  logic [IN_W-1:0] irq_clr,
    output logic [IN_W-1:0] gpio_in,
    output logic [IN_W-1:0] irq_pend,
    output logic            irq
);

    if (DB_TICKS < 1 || DB_TICKS > (1 << DB_W) - 1) begin : g_bad_ticks
        $error("gpio_in_cond: DB_TICKS out of range for DB_W");
    end

    logic [IN_W-1:0] s1;
    logic [IN_W-1:0] s2;
    logic [IN_W-1:0] gpio_nxt;
    logic [IN_W-1:0] rise;
    logic [IN_W-1:0] fall;
    logic [IN_W-1:0] pend_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [DB_W-1:0] TERM = DB_W'(DB_TICKS - 1);

    logic [DB_W-1:0] cnt [IN_W];

    // A new level is accepted on the edge where its run of differing samples reaches DB_TICKS.
    always_comb begin
        gpio_nxt = gpio_in;
        for (int i = 0; i < IN_W; i++) begin
            if (s2[i] != gpio_in[i] && cnt[i] == TERM) begin
                gpio_nxt[i] = s2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (s2[i] == gpio_in[i] || cnt[i] == TERM) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end
`else
    assign gpio_nxt = s2;
`endif

    assign rise     = gpio_nxt & ~gpio_in & rise_en;
    assign fall     = ~gpio_nxt & gpio_in & fall_en;
    // Set is ORed in after the clear so a colliding set wins.
    assign pend_nxt = (irq_pend & ~irq_clr) | rise | fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            gpio_in  <= '0;
            irq_pend <= '0;
            irq      <= 1'b0;
        end else begin
            gpio_in  <= gpio_nxt;
            irq_pend <= pend_nxt;
            irq      <= |pend_nxt;
        end
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: window-based reference model checked every cycle, plus directed literal checks.
module tb_gpio_in_cond;
    localparam int IN_W     = 8;
    localparam int DB_TICKS = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int N = DB_TICKS;
`else
    localparam int N = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [IN_W-1:0] pin_in;
    logic [IN_W-1:0] rise_en;
    logic [IN_W-1:0] fall_en;
    logic [IN_W-1:0] irq_clr;
    logic [IN_W-1:0] gpio_in;
    logic [IN_W-1:0] irq_pend;
    logic            irq;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    gpio_in_cond #(.IN_W(IN_W), .DB_W(16), .DB_TICKS(DB_TICKS)) dut (
        .clk(clk), .rst(rst), .pin_in(pin_in), .rise_en(rise_en), .fall_en(fall_en),
        .irq_clr(irq_clr), .gpio_in(gpio_in), .irq_pend(irq_pend), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit takes a new level once the last N synchronized samples
    // (pin values seen 2..N+1 edges ago, zero before reset) all disagree with it.
    logic [IN_W-1:0] ph [$];
    logic [IN_W-1:0] m_gpio, m_pend, m_nxt;
    logic            m_irq;
    logic            stable, smp;

    always @(posedge clk) begin
        if (!rst) begin
            ph.delete();
            m_gpio = '0;
            m_pend = '0;
            m_irq  = 1'b0;
        end else begin
            m_nxt = m_gpio;
            for (int i = 0; i < IN_W; i++) begin
                stable = 1'b1;
                for (int j = 1; j <= N; j++) begin
                    smp = (j < ph.size()) ? ph[j][i] : 1'b0;
                    if (smp == m_gpio[i]) stable = 1'b0;
                end
                if (stable) m_nxt[i] = ~m_gpio[i];
            end
            for (int i = 0; i < IN_W; i++) begin
                if ((m_nxt[i] && !m_gpio[i] && rise_en[i]) || (!m_nxt[i] && m_gpio[i] && fall_en[i]))
                    m_pend[i] = 1'b1;
                else if (irq_clr[i])
                    m_pend[i] = 1'b0;
            end
            m_gpio = m_nxt;
            m_irq  = |m_pend;
            ph.push_front(pin_in);
            if (ph.size() > N + 2) void'(ph.pop_back());
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_gpio_in", 32'(gpio_in), 32'(m_gpio));
            check("model_irq_pend", 32'(irq_pend), 32'(m_pend));
            check("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; pin_in = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
        step(1);
        cmp_en = 1'b1;
        step(1);
        check("reset_gpio_in", 32'(gpio_in), 32'h0);
        check("reset_irq_pend", 32'(irq_pend), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        step(3);

        // Clean rise on bit 0
        rise_en = 8'h01;
        pin_in[0] = 1'b1;
        step(1 + N);
        check("rise_before_latency", 32'(gpio_in[0]), 32'h0);
        step(1);
        check("rise_gpio", 32'(gpio_in[0]), 32'h1);
        check("rise_pend", 32'(irq_pend), 32'h01);
        check("rise_irq", 32'(irq), 32'h1);

        irq_clr = 8'h01;
        step(1);
        irq_clr = '0;
        check("clear_pend", 32'(irq_pend), 32'h00);
        check("clear_irq", 32'(irq), 32'h0);

        // Bounce on bit 1: high 3, low 1, then steady high
        pin_in[1] = 1'b1;
        step(3);
        pin_in[1] = 1'b0;
        step(1);
        pin_in[1] = 1'b1;
        step(1 + N);
        check("bounce_before_latency", 32'(gpio_in[1]), 32'h0);
        step(1);
        check("bounce_settled", 32'(gpio_in[1]), 32'h1);
        check("bounce_no_pend", 32'(irq_pend), 32'h00);

        // Fall on bit 2 collides with a clear: set wins
        pin_in[2] = 1'b1;
        step(N + 4);
        fall_en = 8'h04;
        pin_in[2] = 1'b0;
        step(1 + N);
        check("fall_before_latency", 32'(gpio_in[2]), 32'h1);
        irq_clr = 8'h04;
        step(1);
        check("fall_gpio", 32'(gpio_in[2]), 32'h0);
        check("collide_set_wins", 32'(irq_pend), 32'h04);
        check("collide_irq", 32'(irq), 32'h1);
        step(1);
        irq_clr = '0;
        check("second_clear_pend", 32'(irq_pend), 32'h00);
        check("second_clear_irq", 32'(irq), 32'h0);

        // Edges with all enables off
        fall_en = '0;
        pin_in = 8'hA5;
        step(2 + N);
        check("disabled_gpio", 32'(gpio_in), 32'hA5);
        check("disabled_pend", 32'(irq_pend), 32'h00);

        // One-cycle pulse on bit 4
        rise_en = 8'h10;
        pin_in[4] = 1'b1;
        step(1);
        pin_in[4] = 1'b0;
        step(1);
        check("pulse_early", 32'(gpio_in[4]), 32'h0);
        step(1);
`ifdef GPIO_IN_DEBOUNCE_EN
        check("pulse_rejected", 32'(gpio_in[4]), 32'h0);
        check("pulse_no_pend", 32'(irq_pend), 32'h00);
`else
        check("pulse_passed", 32'(gpio_in[4]), 32'h1);
        check("pulse_pend", 32'(irq_pend), 32'h10);
`endif
        step(1);
        check("pulse_end", 32'(gpio_in[4]), 32'h0);
        irq_clr = '1;
        step(1);
        irq_clr = '0;

        // Reset in the middle of a debounce count
        rise_en = 8'hFF;
        pin_in = 8'h5A;
        step(3);
        rst = 1'b0;
        step(1);
        check("midreset_gpio", 32'(gpio_in), 32'h00);
        check("midreset_pend", 32'(irq_pend), 32'h00);
        check("midreset_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        step(1 + N);
        check("postreset_before", 32'(gpio_in), 32'h00);
        step(1);
        check("postreset_gpio", 32'(gpio_in), 32'h5A);
        check("postreset_pend", 32'(irq_pend), 32'h5A);
        check("postreset_irq", 32'(irq), 32'h1);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input conditioner placed directly upstream of the GPIO register block. It takes raw asynchronous external input pins, synchronizes them into `clk`, and debounces each bit. It presents a clean `gpio_in` vector that the GPIO block samples on bus reads. It also detects per-bit rising and falling edges on the debounced value and holds them as sticky pending flags with a combined interrupt output.

## Interface

**Parameters**
- `IN_W`, default `8`: number of input pins; equal to the GPIO input width.
- `DB_W`, default `16`: width of each per-bit debounce counter.
- `DB_TICKS`, default `1000`: consecutive stable cycles required to accept a new level. Legal range is `1 ≤ DB_TICKS ≤ 2^DB_W − 1`.

**Ports**
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset. Synchronous, active-low.
- `pin_in`, in, `IN_W`: raw external pins, asynchronous to `clk`.
- `rise_en`, in, `IN_W`: per-bit enable for rising-edge capture.
- `fall_en`, in, `IN_W`: per-bit enable for falling-edge capture.
- `irq_clr`, in, `IN_W`: per-bit clear. Each cycle held high clears that pending bit.
- `gpio_in`, out, `IN_W`: debounced level, registered. Feeds the GPIO block.
- `irq_pend`, out, `IN_W`: sticky edge-pending flags, registered.
- `irq`, out, 1: OR-reduction of `irq_pend`, registered.

## Operation

- **Synchronizer.** Two flops per bit: `pin_in` → `s1` → `s2`. `s2` is the only value the logic downstream uses.
- **Debounce, per bit `i`**, with internal counter `cnt[i]` and `gpio_in[i]` as the accepted level:
  - If `s2[i] == gpio_in[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DB_TICKS−1`: `gpio_in[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - Any single-cycle return to the accepted level restarts the count from 0.
  - The counter never wraps, because it is bounded by `DB_TICKS−1`.
- **Edge capture.** An accept event is the clock edge on which `gpio_in[i]` changes.
  - On an accept 0→1 with `rise_en[i]=1`, set `irq_pend[i]`.
  - On an accept 1→0 with `fall_en[i]=1`, set `irq_pend[i]`.
  - Enables are sampled on the accept edge only. Changing an enable never sets or clears a pending bit by itself.
- **Pending clear.** `irq_clr[i]=1` clears `irq_pend[i]`.
  - If a set and a clear fall on the same edge, set wins.
- **Interrupt output.** `irq <= |(next irq_pend)`. This keeps `irq` aligned with `irq_pend` on the same edge.
- **Reset** (`rst==0` at a clock edge), taken mid-count or mid-bounce with no exception:
  - Cleared to 0: `s1`, `s2`, `gpio_in`, `cnt`, `irq_pend`, `irq`.
  - All state is lost.
- **After reset, pins already high** are accepted as a rising edge after `2+DB_TICKS` cycles. Software must enable `rise_en` only after that, or clear the resulting pending bit.

## Timing

- **Latency.** A clean step on `pin_in` settling before edge E0 appears on `gpio_in` at edge `E0 + 1 + DB_TICKS`:
  - 2 synchronizer edges, then `DB_TICKS−1` counting edges plus 1 accept edge.
  - With `DB_TICKS=1`, latency is 3 edges.
- **Pending and interrupt.** `irq_pend[i]` and `irq` assert on the same edge that `gpio_in[i]` changes.
- **Glitch rejection.** A bounce on `s2` shorter than `DB_TICKS` cycles never reaches `gpio_in`.
- **Clear timing.** A clear is visible on the edge after `irq_clr` is sampled high.
- **Bit independence.** All bits are independent. Simultaneous accepts on several bits set several pending bits on the same edge.
- No handshake. The GPIO block samples `gpio_in` at any time, and the value is always a registered, glitch-free level.

## Configuration

- Macro: `GPIO_IN_DEBOUNCE_EN`.
- **Defined:** debounce counters are present, and the behaviour is exactly as above.
- **Undefined:**
  - No counters are instantiated, and `DB_TICKS` and `DB_W` are ignored.
  - `gpio_in <= s2` every cycle, giving a fixed latency of 3 edges. This is identical to `DB_TICKS=1`.
  - Edge capture, clear and `irq` are unchanged.

## Test plan

- **Clean rise.** `DB_TICKS=4`; `pin_in[0]` 0→1 before edge 0 → `gpio_in[0]=1` and `irq_pend[0]=1` at edge 5 with `rise_en[0]=1`. `irq=1` on the same edge.
- **Bounce rejection.** `DB_TICKS=4`; `pin_in[1]` high for 3 cycles, low for 1, then high steady → no change during the 3-cycle pulse. `gpio_in[1]` goes high 5 edges after the final rise.
- **Set/clear collision.** Accept a fall on bit 2 with `fall_en[2]=1` on the same edge `irq_clr[2]=1` → `irq_pend[2]=1`. Pulse `irq_clr[2]` one more cycle → `irq_pend[2]=0` and `irq=0`.
- **Disabled edges.** `rise_en=fall_en=0`; toggle `pin_in=8'hA5` → `gpio_in=8'hA5` after latency, with `irq_pend` staying `8'h00`.
- **Reset mid-count.** `DB_TICKS=8`; assert `rst=0` for one edge while `cnt[3]=5` → next cycle all outputs are 0. The new level needs a full `2+DB_TICKS` edges afterwards.
- **Build without `GPIO_IN_DEBOUNCE_EN`.** One-cycle pulse on `pin_in[4]` → one-cycle pulse on `gpio_in[4]` delayed 3 edges, and `irq_pend[4]` sets if `rise_en[4]=1`.
